// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared constants and state encoding for the instruction-memory loader
package im_pkg;

  localparam int IM_ROM_WIDTH     = 32;
  localparam int IM_ROM_ADDR_BITS = 64;
  localparam int BYTES_PER_WORD   = 4;
  localparam int WORD_BITS        = BYTES_PER_WORD * 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/im_word_packer.sv
// rtl/im_word_packer.sv - little-endian byte-to-word assembler with a 2-bit lane counter
module im_word_packer
  import im_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word
);

  logic [1:0]           lane;
  logic [WORD_BITS-9:0] shreg;

  // Only the first three bytes are stored; the fourth is merged combinationally.
  assign word_valid = byte_valid && (lane == 2'd3);
  assign word       = {byte_data, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= 2'd0;
      shreg <= '0;
    end else if (clr) begin
      lane  <= 2'd0;
      shreg <= '0;
    end else if (byte_valid) begin
      lane  <= lane + 2'd1;
      shreg <= {byte_data, shreg[WORD_BITS-9:8]};
    end
  end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - fills instruction memory from a length-prefixed byte stream while holding the core
module im_loader
  import im_pkg::*;
#(
  parameter int ROM_WIDTH     = IM_ROM_WIDTH,
  parameter int ROM_ADDR_BITS = IM_ROM_ADDR_BITS,
  parameter int ADDR_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 im_we,
  output logic [ADDR_W-1:0]    im_addr,
  output logic [ROM_WIDTH-1:0] im_wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  logic [2:0]        state;
  logic [7:0]        len_lo;
  logic [15:0]       words_left;
  logic [ADDR_W-3:0] word_idx;
  logic              accept;
  logic              start_ok;
  logic              pk_word_valid;
  logic [WORD_BITS-1:0] pk_word;
  logic [15:0]       len_full;

  assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign len_full = {in_data, len_lo};

  im_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .byte_valid (accept && (state == S_DATA)),
    .byte_data  (in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      words_left <= '0;
      word_idx   <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state    <= S_LEN_LO;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            word_idx <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            words_left <= len_full;
            if (len_full == 16'd0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_DATA;
              err   <= int'(len_full) > ROM_ADDR_BITS;
            end
          end
        end
        S_DATA: begin
          if (pk_word_valid) begin
            // Words past the end of IM are consumed but never written.
            if (int'(word_idx) < ROM_ADDR_BITS) begin
              im_we    <= 1'b1;
              im_addr  <= {word_idx, 2'b00};
              im_wdata <= pk_word;
            end
            if (word_idx != '1) word_idx <= word_idx + 1'b1;
            words_left <= words_left - 16'd1;
            if (words_left == 16'd1) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          state    <= S_DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed scoreboard bench for im_loader
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  int we_base;
  logic [15:0] last_addr = 16'h0;
  logic [47:0] sb[$];

  im_loader #(.ROM_WIDTH(32), .ROM_ADDR_BITS(64), .ADDR_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst_n === 1'b1 && im_we === 1'b1) begin
      we_count++;
      last_addr = im_addr;
      if (sb.size() == 0) begin
        check("unexpected_we_addr", {16'h0, im_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("we_addr", {16'h0, im_addr}, {16'h0, e[47:32]});
        check("we_data", im_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic push_word(input logic [15:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_im_we"},    {31'h0, im_we},    32'h0);
    check({tag, "_im_addr"},  {16'h0, im_addr},  32'h0);
    check({tag, "_im_wdata"}, im_wdata,          32'h0);
    check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, 32'h0);
    check({tag, "_done"},     {31'h0, done},     32'h0);
    check({tag, "_err"},      {31'h0, err},      32'h0);
  endtask

  task automatic basic_stream(input bit gap, input bit mid_start);
    logic [7:0] bytes [0:9];
    bytes = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h60, 8'h05, 8'hF3, 8'h12, 8'h55, 8'h00};
    push_word(16'h0000, 32'h0560_0513);
    push_word(16'h0004, 32'h0055_12F3);
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[i], gap);
      if (mid_start && i == 4) pulse_start();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {31'h0, in_ready}, 32'h0);

    // Basic load
    we_base = we_count;
    pulse_start();
    check("basic_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    basic_stream(1'b0, 1'b0);
    check("basic_flush_we", {31'h0, im_we}, 32'h1);
    check("basic_flush_done", {31'h0, done}, 32'h0);
    check("basic_flush_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    check("basic_done", {31'h0, done}, 32'h1);
    check("basic_hold", {31'h0, cpu_hold}, 32'h0);
    check("basic_err", {31'h0, err}, 32'h0);
    check("basic_we_count", 32'(we_count - we_base), 32'd2);
    check("basic_sb_empty", 32'(sb.size()), 32'd0);

    // Zero length
    we_base = we_count;
    pulse_start();
    check("zero_done_cleared", {31'h0, done}, 32'h0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("zero_done", {31'h0, done}, 32'h1);
    check("zero_err", {31'h0, err}, 32'h0);
    check("zero_hold", {31'h0, cpu_hold}, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("zero_we_count", 32'(we_count - we_base), 32'd0);

    // Handshake gaps
    we_base = we_count;
    pulse_start();
    basic_stream(1'b1, 1'b0);
    @(posedge clk); #1;
    check("gap_done", {31'h0, done}, 32'h1);
    check("gap_we_count", 32'(we_count - we_base), 32'd2);
    check("gap_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow: 65 words into a 64-word IM
    we_base = we_count;
    pulse_start();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    check("ovf_err_early", {31'h0, err}, 32'h1);
    for (int w = 0; w < 65; w++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4*w) ^ 8'hA5; b1 = 8'(4*w+1) ^ 8'hA5;
      b2 = 8'(4*w+2) ^ 8'hA5; b3 = 8'(4*w+3) ^ 8'hA5;
      if (w < 64) push_word(16'(4*w), {b3, b2, b1, b0});
      send_byte(b0, 1'b0); send_byte(b1, 1'b0);
      send_byte(b2, 1'b0); send_byte(b3, 1'b0);
    end
    repeat (2) @(posedge clk); #1;
    check("ovf_we_count", 32'(we_count - we_base), 32'd64);
    check("ovf_last_addr", {16'h0, last_addr}, 32'h0000_00FC);
    check("ovf_err", {31'h0, err}, 32'h1);
    check("ovf_done", {31'h0, done}, 32'h1);
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);

    // Restart from DONE, with an ignored start during DATA
    we_base = we_count;
    pulse_start();
    check("restart_done_clr", {31'h0, done}, 32'h0);
    check("restart_err_clr", {31'h0, err}, 32'h0);
    basic_stream(1'b0, 1'b1);
    @(posedge clk); #1;
    check("restart_done", {31'h0, done}, 32'h1);
    check("restart_we_count", 32'(we_count - we_base), 32'd2);
    check("restart_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-load after six data bytes
    pulse_start();
    push_word(16'h0000, 32'h0403_0201);
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    check("midrst_hold_before", {31'h0, cpu_hold}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    check("post_rst_done", {31'h0, done}, 32'h0);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Write-side counterpart of the instruction memory (IM). IM is read combinationally at word index pc>>2; this block fills it.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the IM write port at byte addresses 0, 4, 8, …
- Holds the core stalled (cpu_hold) while loading. Sits between a host/UART byte source and IM.

Parameters:
- ROM_WIDTH, 32, instruction word width; must be 32.
- ROM_ADDR_BITS, 64, IM depth in words.
- ADDR_W, 16, byte-address width; matches the pc width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load session.
- in_valid  in  1  byte available.
- in_data  in  8  byte value.
- in_ready  out  1  byte accepted when in_valid && in_ready at a rising edge.
- im_we  out  1  IM write strobe, one cycle per word.
- im_addr  out  ADDR_W  IM byte address, word-aligned (bits [1:0] = 0).
- im_wdata  out  ROM_WIDTH  word to write.
- cpu_hold  out  1  high from start acceptance until DONE.
- done  out  1  load finished; held until the next start.
- err  out  1  declared length exceeded ROM_ADDR_BITS; held until the next start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0; internal counters and the assembly register cleared. Deassertion is synchronous to clk. Reset mid-load abandons the session; words already written stay in IM.
- States: IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE.
- IDLE: in_ready=0. On start go to LEN_LO; clear done, err, word_idx, byte_cnt; cpu_hold=1 from the next cycle.
- LEN_LO: in_ready=1. On accept, latch N[7:0] and go to LEN_HI.
- LEN_HI: in_ready=1. On accept, latch N[15:8].
  - If the full N=0, go to DONE.
  - Otherwise go to DATA; err=1 if N>ROM_ADDR_BITS.
- DATA: in_ready=1.
  - Each accepted byte fills lane byte_cnt (byte 0 → bits [7:0]); byte_cnt wraps 3→0.
  - On the 4th byte, the next cycle has im_we=1, im_addr=word_idx<<2 and the assembled word on im_wdata. Write latency is 1 cycle after the 4th handshake. word_idx then increments.
  - Writes with word_idx >= ROM_ADDR_BITS are suppressed (im_we stays 0). Their bytes are still consumed so the stream stays aligned.
  - When the N-th word's 4th byte is accepted, go to FLUSH.
- FLUSH: in_ready=0. Issues the final write cycle, then goes to DONE.
- DONE: in_ready=0, cpu_hold=0, done=1. On start, restart as from IDLE.
- im_we is high for exactly one cycle per word and never two cycles in a row without 4 new handshakes. im_addr and im_wdata are stable while im_we=1 and hold their last value otherwise.
- in_valid is ignored while in_ready=0. in_data is ignored without in_valid; gaps in in_valid of any length are allowed.
- start while in LEN_LO, LEN_HI, DATA or FLUSH is ignored.
- word_idx is ADDR_W-2 bits wide; it saturates at its max and never wraps. N is at most 65535.

Decomposition:
- Shared package im_pkg:
  - state encoding: IDLE=0, LEN_LO=1, LEN_HI=2, DATA=3, FLUSH=4, DONE=5.
  - ROM_WIDTH and ROM_ADDR_BITS defaults, shared with IM.
  - BYTES_PER_WORD=4.
- One sub-module, im_word_packer: byte shift-in register with a 2-bit lane counter, outputs word_valid and word. The FSM, length handling and address generation live in im_loader.
- IM must gain a synchronous write port (we, byte addr >> 2, wdata) to pair with this block.

Test Plan:
- Basic load: start; bytes 02 00 | 13 05 60 05 | F3 12 55 00.
  - im_we pulses twice: addr 0x0000 data 0x05600513, then addr 0x0004 data 0x005512F3.
  - done=1 and cpu_hold=0 one cycle after the FLUSH write.
- Zero length: start; bytes 00 00.
  - No im_we; done=1 two handshakes after start; err=0.
- Handshake gaps: same stream as basic load with in_valid toggled 1/0 randomly.
  - Identical writes and data; exactly 2 im_we pulses.
- Overflow: ROM_ADDR_BITS=64, N=65 (41 00), 260 data bytes.
  - 64 writes, last at addr 0x00FC; err=1; 65th word suppressed; done=1.
- Reset mid-load: assert rst_n=0 after 6 data bytes.
  - All outputs 0 immediately (async); after release state is IDLE and in_ready=0 until start.
- Restart and ignored start: start pulse during DATA has no effect. A start in DONE clears done and err and reloads from addr 0x0000.
